// File: rtl/btn_pkg.sv
// Shared constants and helpers for the button-driven hex digit controller.
package btn_pkg;

    // 10 ms stability window at 100 MHz
    localparam int unsigned DEB_CYCLES_DEFAULT = 1_000_000;
    localparam int unsigned NUM_DIGITS         = 4;
    localparam int unsigned DIGIT_W            = 4;

    // One modulo-16 step of a hex digit; dec=1 steps down, wrapping 0 -> F.
    function automatic logic [DIGIT_W-1:0] digit_step(input logic [DIGIT_W-1:0] d,
                                                      input logic               dec);
        return dec ? d - 1'b1 : d + 1'b1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One-button conditioner: 2-flop synchronizer, stability counter, debounced
// level and a registered one-cycle strobe on each debounced rising edge.
module btn_debounce #(
    parameter int unsigned DebCycles = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic rise_o,
    output logic pulse_o
);

    localparam int unsigned     CntW   = (DebCycles > 1) ? $clog2(DebCycles) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DebCycles - 1);

    logic            sync1_q, sync2_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            deb_q, deb_d;
    logic            deb_prev_q;
    logic            pulse_q;

    // Count consecutive cycles the synchronized input disagrees with deb; flip on the last one.
    always_comb begin
        cnt_d = '0;
        deb_d = deb_q;
        if (sync2_q != deb_q) begin
            if (cnt_q == CntMax) begin
                deb_d = ~deb_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Debounced rising edge, seen one cycle after deb goes high.
    assign rise_o = deb_q & ~deb_prev_q;

    // Synchronizer, counter, debounced level and strobe registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            cnt_q      <= '0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            pulse_q    <= 1'b0;
        end else begin
            sync1_q    <= btn_i;
            sync2_q    <= sync1_q;
            cnt_q      <= cnt_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            pulse_q    <= rise_o;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/btn_digit_ctrl.sv
// Four debounced buttons each step one hex digit up or down; SW[1] clears all.
module btn_digit_ctrl
    import btn_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_DIGITS-1:0]         btn,
    input  logic [7:0]                    SW,
    output logic [NUM_DIGITS*DIGIT_W-1:0] num,
    output logic [NUM_DIGITS-1:0]         btn_pulse,
    output logic                          BTNX4
);

    logic [NUM_DIGITS-1:0]         rise;
    logic [NUM_DIGITS*DIGIT_W-1:0] num_q, num_d;
    logic                          unused_sw;

    assign unused_sw = ^SW[7:2];

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : gen_deb
        btn_debounce #(
            .DebCycles(DEB_CYCLES)
        ) u_deb (
            .clk_i  (clk),
            .rst_ni (rst_n),
            .btn_i  (btn[g]),
            .rise_o (rise[g]),
            .pulse_o(btn_pulse[g])
        );
    end

    // Step every pressed digit on the strobe edge; clear switch overrides presses.
    always_comb begin
        num_d = num_q;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (rise[i]) begin
                num_d[i*DIGIT_W +: DIGIT_W] = digit_step(num_q[i*DIGIT_W +: DIGIT_W], SW[0]);
            end
        end
        if (SW[1]) begin
            num_d = '0;
        end
    end

    // Digit register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            num_q <= '0;
        end else begin
            num_q <= num_d;
        end
    end

    assign num   = num_q;
    assign BTNX4 = 1'b0;

endmodule

// File: tb/tb_btn_digit_ctrl.sv
// Scoreboard bench for btn_digit_ctrl with a short debounce window.
module tb_btn_digit_ctrl;

    localparam int unsigned DEB = 4;

    logic        clk;
    logic        rst_n;
    logic [3:0]  btn;
    logic [7:0]  SW;
    logic [15:0] num;
    logic [3:0]  btn_pulse;
    logic        BTNX4;

    btn_digit_ctrl #(
        .DEB_CYCLES(DEB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn      (btn),
        .SW       (SW),
        .num      (num),
        .btn_pulse(btn_pulse),
        .BTNX4    (BTNX4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  mask;
        logic [15:0] num;
        int unsigned cyc;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
        end
    endtask

    // Reference model: edge-by-edge view of the button rules.
    int unsigned cyc = 0;
    logic [3:0]  h1 = '0, h2 = '0;
    int          run[4] = '{0, 0, 0, 0};
    logic [3:0]  mdeb = '0, mpend = '0;
    logic [15:0] mnum = '0;

    always @(posedge clk) begin
        logic [3:0] din;
        logic [3:0] newpend;
        exp_t e;
        cyc++;
        if (!rst_n) begin
            h1 = '0; h2 = '0; mdeb = '0; mpend = '0; mnum = '0;
            for (int i = 0; i < 4; i++) run[i] = 0;
        end else begin
            din = h2;  // btn as sampled two edges ago
            for (int i = 0; i < 4; i++) begin
                if (mpend[i]) begin
                    if (SW[0]) mnum[4*i +: 4] = (mnum[4*i +: 4] + 4'd15) % 16;
                    else       mnum[4*i +: 4] = (mnum[4*i +: 4] + 4'd1) % 16;
                end
            end
            if (SW[1]) mnum = '0;
            if (mpend != 0) begin
                e.mask = mpend; e.num = mnum; e.cyc = cyc;
                exp_q.push_back(e);
            end
            newpend = '0;
            for (int i = 0; i < 4; i++) begin
                if (din[i] != mdeb[i]) begin
                    run[i]++;
                    if (run[i] == int'(DEB)) begin
                        mdeb[i] = ~mdeb[i];
                        run[i] = 0;
                        if (mdeb[i]) newpend[i] = 1'b1;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            mpend = newpend;
            h2 = h1;
            h1 = btn;
        end
    end

    // Monitor: compare every cycle and pop on each presented strobe.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            chk("num", 32'(num), 32'(mnum));
            chk("btnx4", 32'(BTNX4), 32'd0);
            if (btn_pulse != 0 || (exp_q.size() > 0 && exp_q[0].cyc <= cyc)) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_pulse", 32'(btn_pulse), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_mask", 32'(btn_pulse), 32'(e.mask));
                    chk("pulse_num", 32'(num), 32'(e.num));
                    chk("pulse_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic press(input int b, input int hi, input int lo);
        btn[b] = 1'b1;
        tick(hi);
        btn[b] = 1'b0;
        tick(lo);
    endtask

    int hold[4];

    initial begin
        rst_n = 1'b0;
        btn   = '0;
        SW    = '0;
        tick(1);
        mon_en = 1'b1;
        tick(2);
        rst_n = 1'b1;

        // Idle after reset
        tick(20);

        // Single held press of button 0
        btn[0] = 1'b1;
        tick(20);
        btn[0] = 1'b0;
        tick(10);
        chk("held_press_num", 32'(num), 32'h0001);

        // Glitch train on button 2
        for (int j = 0; j < 2; j++) begin
            btn[2] = 1'b1; tick(2);
            btn[2] = 1'b0; tick(2);
        end
        tick(10);
        chk("glitch_num", 32'(num), 32'h0001);

        // Sixteen presses up, then one down
        do_reset();
        for (int j = 0; j < 16; j++) press(3, 8, 8);
        chk("wrap_up_num", 32'(num), 32'h0000);
        SW[0] = 1'b1;
        press(3, 8, 8);
        chk("wrap_down_num", 32'(num), 32'hF000);
        SW[0] = 1'b0;

        // All four together, then clear
        do_reset();
        btn = 4'b1111;
        tick(12);
        chk("all_num", 32'(num), 32'h1111);
        SW[1] = 1'b1;
        tick(1);
        chk("clear_num", 32'(num), 32'h0000);
        SW[1] = 1'b0;
        btn = '0;
        tick(10);

        // Reset in the middle of a press on button 1
        do_reset();
        tick(5);
        btn[1] = 1'b1;
        tick(3);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(20);
        chk("reset_mid_num", 32'(num), 32'h0010);
        btn[1] = 1'b0;
        tick(10);

        // Random bouncing buttons, switch changes and occasional resets
        for (int i = 0; i < 4; i++) hold[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (hold[i] == 0) begin
                    btn[i]  = ~btn[i];
                    hold[i] = $urandom_range(1, 9);
                end
                hold[i]--;
            end
            if ($urandom_range(0, 49) == 0) begin
                SW = 8'($urandom);
                if ($urandom_range(0, 3) != 0) SW[1] = 1'b0;
            end
            rst_n = ($urandom_range(0, 399) != 0);
            tick(1);
        end
        rst_n = 1'b1;
        btn   = '0;
        tick(15);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btn_digit_ctrl.md
BTN_DIGIT_CTRL -- requirements
Module: btn_digit_ctrl

Interface
REQ-001 Parameter: DEB_CYCLES, default 1_000_000, debounce stability window in clk cycles (10 ms at 100 MHz); legal range 2..2^20.
REQ-002 Clocking: one clock, clk; reset is synchronous and active-low, rst_n.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 btn  input  4  raw asynchronous push buttons, active-high, bouncing.
REQ-006 SW  input  8  slide switches; SW[0]=direction (0 inc, 1 dec), SW[1]=clear, SW[7:2] unused.
REQ-007 num  output  16  four hex digits for the display stage; digit i = num[4i+3:4i].
REQ-008 btn_pulse  output  4  registered one-cycle press strobe per button.
REQ-009 BTNX4  output  1  button-matrix column drive, constant 0.

Function
REQ-010 Each btn[i] SHALL pass a 2-flop synchronizer before any other use.
REQ-011 Per button: debounced state deb[i] and counter cnt[i] of width clog2(DEB_CYCLES).
REQ-012 When synchronized input equals deb[i], cnt[i] SHALL clear to 0.
REQ-013 When it differs, cnt[i] SHALL increment; on the edge where cnt[i]==DEB_CYCLES-1 and still differing, deb[i] SHALL toggle and cnt[i] SHALL clear.
REQ-014 Any glitch shorter than DEB_CYCLES consecutive cycles SHALL leave deb[i] unchanged.
REQ-015 btn_pulse[i] SHALL be high for exactly one cycle per 0->1 transition of deb[i]; 1->0 transitions produce no pulse.
REQ-016 Latency: btn[i] first sampled high at edge k and held -> btn_pulse[i] high and num updated after edge k+DEB_CYCLES+2.
REQ-017 On a press of button i with SW[0]=0, digit i SHALL increment modulo 16 (F->0).
REQ-018 On a press of button i with SW[0]=1, digit i SHALL decrement modulo 16 (0->F).
REQ-019 Digits are independent; simultaneous presses SHALL update every pressed digit on the same edge.
REQ-020 SW[1]=1 SHALL force num to 0x0000 on every edge, overriding presses; btn_pulse still asserts normally.
REQ-021 SW[0] and SW[1] SHALL be sampled directly on the update edge, without synchronizer or debounce.
REQ-022 A button held continuously SHALL yield exactly one pulse and one digit step.

Reset
REQ-023 While rst_n=0 at an edge: num=0x0000, btn_pulse=0, deb=0, cnt=0, synchronizer flops=0.
REQ-024 Reset asserted mid-debounce SHALL discard partial counts; no pulse emitted for that press.
REQ-025 A button held high through reset release SHALL produce one pulse DEB_CYCLES+2 edges after the first post-reset edge.
REQ-026 BTNX4 SHALL be 0 regardless of reset.

Structure
REQ-027 Shared package btn_pkg SHALL hold DEB_CYCLES_DEFAULT, NUM_DIGITS=4 and DIGIT_W=4.
REQ-028 Sub-module btn_debounce (synchronizer + counter + deb + edge pulse, one button) SHALL be instantiated 4 times; digit update logic stays in btn_digit_ctrl.
REQ-029 Target size 120-400 RTL lines total; no latches, no combinational path from btn to any output.

Verification (DEB_CYCLES=4)
REQ-030 Reset, then btn=0 for 20 cycles -> num=0x0000, btn_pulse=0, BTNX4=0 throughout.
REQ-031 btn[0] high at edge k, held 20 cycles, SW=0 -> btn_pulse[0] high only after edge k+6; num=0x0001; no second pulse.
REQ-032 btn[2] toggled 1,0,1,0 at 2-cycle spacing, then low -> no pulse; num unchanged.
REQ-033 Sixteen clean presses of btn[3] with SW[0]=0 -> num[15:12] walks 1..F then 0; then SW[0]=1, one press -> num=0xF000.
REQ-034 btn=4'b1111 held simultaneously from num=0x0000 -> all four btn_pulse bits together; num=0x1111; then SW[1]=1 -> num=0x0000 next edge.
REQ-035 btn[1] pressed; rst_n low for 1 cycle at edge k+3 with btn held -> num=0x0000, no pulse before edge k+4+6; exactly one pulse after.
